// File: rtl/edabk_transmitter_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Provides CFG_DATA_WIDTH when the build does not define it.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

package edabk_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_FIN,
        RELEASE
    } arb_state_t;

    localparam int NUM_REQ_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/edabk_transmitter_arbiter_if.sv
// Requester-side and transmitter-side signals of the arbiter.
// master: arbiter view, slave: sources plus transmitter view.
interface edabk_transmitter_arbiter_if
    import edabk_uart_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_parity;
    logic [NUM_REQ-1:0]            ack;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_parity;
    logic                          tx_finish;
    logic                          busy;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          timeout_err;

    modport master (
        input  req, req_data, req_parity, tx_finish,
        output ack, tx_start, tx_data, tx_parity,
        output busy, grant_id, timeout_err
    );

    modport slave (
        output req, req_data, req_parity, tx_finish,
        input  ack, tx_start, tx_data, tx_parity,
        input  busy, grant_id, timeout_err
    );

endinterface

// File: rtl/edabk_rr_picker.sv
// Round-robin search: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module edabk_rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic                valid_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    int j;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = ID_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/edabk_transmitter_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among requesters.
// EDABK_TX_ARB_TIMEOUT_EN adds a sticky tx_finish watchdog.
module edabk_transmitter_arbiter
    import edabk_uart_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
`ifdef EDABK_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input logic bclk,
    input logic reset_n,
    edabk_transmitter_arbiter_if.master bus
);

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  pick_valid;
    logic [ID_WIDTH-1:0]   pick_idx;

    edabk_rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef EDABK_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    // Cycles spent in WAIT_FIN; zero on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT_FIN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Next state, grant latch and registered output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        par_d   = par_q;
`ifdef EDABK_TX_ARB_TIMEOUT_EN
        terr_d  = terr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    data_d  = bus.req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    par_d   = bus.req_parity[pick_idx];
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT_FIN;
            end
            WAIT_FIN: begin
                if (bus.tx_finish) begin
                    state_d = RELEASE;
                end
`ifdef EDABK_TX_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    state_d = RELEASE;
                end
`endif
            end
            RELEASE: begin
                ptr_d   = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ?
                          '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
        ack_d   = (state_d == RELEASE) ?
                  (NUM_REQ'(1) << grant_d) : '0;
    end

    // State and output registers.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_parity = par_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_edabk_transmitter_arbiter.sv
// Bench for edabk_transmitter_arbiter: directed cases plus random
// request mixes against a rotating-priority reference model.
module tb_edabk_transmitter_arbiter;

    logic bclk;
    logic reset_n;
    int   n_checks;
    int   n_err;
    int   rr_m;
    int   g_last;
    logic [3:0] pend;
    logic [3:0] addm;

    edabk_transmitter_arbiter_if #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8)
    ) bus ();

    edabk_transmitter_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8)
`ifdef EDABK_TX_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (20)
`endif
    ) dut (
        .bclk    (bclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
        chk({tag, "_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic set_payload(input int i, input logic [7:0] d,
                               input logic p);
        bus.req_data[i*8 +: 8] = d;
        bus.req_parity[i]      = p;
    endtask

    // Reference: first pending requester at or after rr_m, cyclic.
    function automatic int model_pick(input logic [3:0] r, input int ptr);
        int g;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && r[(ptr + k) % 4]) g = (ptr + k) % 4;
        end
        return g;
    endfunction

    // One full frame; transmitter answers 12 cycles after tx_start.
    task automatic frame(input bit drop, input logic [7:0] newdat,
                         output int g);
        logic [7:0] ed;
        logic       ep;
        g = model_pick(bus.req, rr_m);
        if (g < 0) begin
            chk("no_request_for_frame", 32'(bus.req), 32'd1);
            g = 0;
        end
        ed = bus.req_data[g*8 +: 8];
        ep = bus.req_parity[g];
        @(posedge bclk); #1;
        chk("start", 32'(bus.tx_start), 32'd1);
        chk("grant", 32'(bus.grant_id), 32'(g));
        chk("data", 32'(bus.tx_data), 32'(ed));
        chk("parity", 32'(bus.tx_parity), 32'(ep));
        chk("busy_start", 32'(bus.busy), 32'd1);
        chk("ack_early", 32'(bus.ack), 32'd0);
        @(posedge bclk); #1;
        chk("start_pulse", 32'(bus.tx_start), 32'd0);
        if (drop) begin
            bus.req[g]           = 1'b0;
            bus.req_data[g*8 +: 8] = newdat;
        end
        repeat (10) @(posedge bclk);
        #1;
        chk("ack_wait", 32'(bus.ack), 32'd0);
        bus.tx_finish = 1'b1;
        @(posedge bclk); #1;
        bus.tx_finish = 1'b0;
        chk("ack", 32'(bus.ack), 32'(4'b0001 << g));
        chk("data_hold", 32'(bus.tx_data), 32'(ed));
        chk("busy_rel", 32'(bus.busy), 32'd1);
        rr_m = (g + 1) % 4;
        @(posedge bclk); #1;
        chk_idle_outputs("after_ack");
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rr_m          = 0;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_parity = '0;
        bus.tx_finish = 1'b0;
        repeat (3) @(posedge bclk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_data", 32'(bus.tx_data), 32'd0);
        chk("reset_par", 32'(bus.tx_parity), 32'd0);
        chk("reset_gid", 32'(bus.grant_id), 32'd0);
        chk("reset_terr", 32'(bus.timeout_err), 32'd0);
        reset_n = 1'b1;
        @(posedge bclk); #1;

        // Single request from requester 1.
        set_payload(1, 8'hA5, 1'b1);
        bus.req = 4'b0010;
        frame(1'b0, 8'h00, g_last);
        bus.req = '0;

        // Stray finish while idle.
        @(posedge bclk); #1;
        bus.tx_finish = 1'b1;
        @(posedge bclk); #1;
        bus.tx_finish = 1'b0;
        chk_idle_outputs("stray1");
        @(posedge bclk); #1;
        chk_idle_outputs("stray2");

        // Reset during WAIT_FIN abandons the frame.
        set_payload(0, 8'h5A, 1'b0);
        bus.req = 4'b0001;
        repeat (3) @(posedge bclk);
        #1;
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_data", 32'(bus.tx_data), 32'd0);
        chk("async_rst_gid", 32'(bus.grant_id), 32'd0);
        rr_m    = 0;
        bus.req = '0;
        repeat (2) @(posedge bclk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge bclk); #1;
            chk("no_ack_after_rst", 32'(bus.ack), 32'd0);
        end
        set_payload(1, 8'h11, 1'b0);
        set_payload(3, 8'h33, 1'b1);
        bus.req = 4'b1010;
        frame(1'b0, 8'h00, g_last);
        bus.req = '0;

        // Restart from reset, then all four held high.
        reset_n = 1'b0;
        rr_m    = 0;
        @(posedge bclk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_payload(i, 8'(8'h10 + 8'h21 * i), i[0]);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            frame(1'b0, 8'h00, g_last);
            chk("rr_order", 32'(g_last), 32'(k % 4));
        end
        bus.req = '0;

        // Requester 2 drops req and changes data mid-transfer.
        set_payload(2, 8'h3C, 1'b1);
        bus.req = 4'b0100;
        frame(1'b1, 8'h00, g_last);
        bus.req = '0;

`ifdef EDABK_TX_ARB_TIMEOUT_EN
        // Transmitter never finishes: watchdog releases the frame.
        set_payload(0, 8'h77, 1'b0);
        bus.req = 4'b0001;
        g_last = model_pick(bus.req, rr_m);
        @(posedge bclk); #1;
        chk("to_start", 32'(bus.tx_start), 32'd1);
        repeat (20) @(posedge bclk);
        #1;
        chk("to_ack_early", 32'(bus.ack), 32'd0);
        chk("to_terr_early", 32'(bus.timeout_err), 32'd0);
        @(posedge bclk); #1;
        chk("to_ack", 32'(bus.ack), 32'(4'b0001 << g_last));
        chk("to_terr", 32'(bus.timeout_err), 32'd1);
        rr_m    = (g_last + 1) % 4;
        bus.req = '0;
        @(posedge bclk); #1;
        set_payload(3, 8'h99, 1'b1);
        bus.req = 4'b1000;
        frame(1'b0, 8'h00, g_last);
        bus.req = '0;
        chk("to_sticky", 32'(bus.timeout_err), 32'd1);
`endif

        // Random request mixes.
        pend = '0;
        for (int n = 0; n < 30; n++) begin
            addm = 4'($urandom_range(0, 15)) & ~pend;
            if ((pend | addm) == 4'b0000) addm = 4'b0001 << $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                if (addm[i]) set_payload(i, 8'($urandom), 1'($urandom));
            end
            pend    = pend | addm;
            bus.req = pend;
            frame(($urandom % 3) == 0, 8'($urandom), g_last);
            pend = bus.req;
            if (pend[g_last] && ($urandom % 2) == 0) pend[g_last] = 1'b0;
            if (pend[g_last]) set_payload(g_last, 8'($urandom), 1'($urandom));
            bus.req = pend;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/edabk_transmitter_arbiter.md
Name: edabk_transmitter_arbiter

Overview:
- Shares one UART transmit path (transmitter controller plus datapath) between NUM_REQ requesters.
- Each requester presents a byte and a parity-enable flag. The arbiter grants one requester at a time, round-robin, and latches its payload.
- It pulses the transmitter's start, waits for the transmitter's finish, then acknowledges the granted requester.
- Sits between host-side sources (CPU regs, debug port, loopback) and the transmitter, in the bclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, `CFG_DATA_WIDTH, payload bits per frame
- ID_WIDTH, $clog2(NUM_REQ), width of grant index
- TIMEOUT_CYC, 4096, bclk cycles allowed between tx_start and tx_finish (optional feature only)

Ports:
- bclk  input  1  baud clock
- reset_n  input  1  asynchronous reset, active low
- req  input  NUM_REQ  per-requester request, level
- req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- req_parity  input  NUM_REQ  per-requester parity-enable
- ack  output  NUM_REQ  one-hot, one-cycle pulse: frame of requester i transmitted
- tx_start  output  1  start pulse to transmitter controller
- tx_data  output  DATA_WIDTH  latched payload to transmitter datapath
- tx_parity  output  1  latched parity-enable to transmitter controller
- tx_finish  input  1  transmitter finished frame
- busy  output  1  high whenever state != IDLE
- grant_id  output  ID_WIDTH  index of current or last granted requester
- timeout_err  output  1  sticky watchdog error (optional feature only; tied 0 otherwise)

Behaviour:
- All outputs are registered. Reset values: ack=0, tx_start=0, tx_data=0, tx_parity=0, busy=0, grant_id=0, timeout_err=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, START, WAIT_FIN, RELEASE.
- IDLE:
  - If req != 0, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch grant_id, tx_data and tx_parity from that requester, then go to START.
  - Otherwise stay in IDLE.
- START: tx_start=1 for exactly this one cycle, then go to WAIT_FIN.
- WAIT_FIN:
  - tx_finish=1 -> go to RELEASE.
  - Otherwise stay in WAIT_FIN.
- RELEASE:
  - ack[grant_id]=1 for one cycle.
  - rr_ptr <= (grant_id+1) mod NUM_REQ, computed with explicit wrap for non-power-of-2 NUM_REQ.
  - Go to IDLE.
- Latency:
  - req sampled at edge k in IDLE -> tx_start high in cycle k+1.
  - tx_finish sampled at edge m -> ack high in cycle m+1.
  - Minimum gap between back-to-back tx_start pulses: tx_finish latency + 3 cycles.
- Handshake rules:
  - A requester holds req, req_data and req_parity stable until its ack.
  - req is sampled only in IDLE. Payload is latched at grant, so later changes to req_data are ignored.
  - If req drops after grant, the transfer still completes and ack still pulses.
  - A requester holding req high after its ack is eligible again, but only after the others, because of the rr_ptr update.
- tx_finish outside WAIT_FIN is ignored.
- Simultaneous requests: exactly one grant per round, fairness by rotating priority. With all req high, the grant order is 0,1,2,3,0,...
- Reset asserted mid-operation: immediate return to reset values. Any in-flight frame is abandoned without ack, and tx_start is deasserted asynchronously.
- tx_data and tx_parity hold their value until the next grant.

Optional Feature:
- Macro: EDABK_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entering WAIT_FIN and increments each cycle in WAIT_FIN.
  - On reaching TIMEOUT_CYC without tx_finish: set timeout_err (sticky until reset), go to RELEASE and ack as normal so the requester is not blocked.
  - If tx_finish and the timeout occur in the same cycle, tx_finish wins and timeout_err is not set.
- Undefined: no counter, timeout_err tied 0, WAIT_FIN waits indefinitely.

Decomposition:
- Package edabk_uart_pkg holds:
  - state enum arb_state_t {IDLE, START, WAIT_FIN, RELEASE}
  - default NUM_REQ
  - TIMEOUT_CYC default
- Sub-module edabk_rr_picker: combinational round-robin search (req, rr_ptr -> valid, idx). It is instantiated once in the arbiter.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, transmitter model asserts tx_finish 12 cycles after tx_start):
- Single request: req=0010, req_data[1]=0xA5, parity=1 -> tx_start pulse the cycle after sampling; tx_data=0xA5, tx_parity=1, grant_id=1; ack=0010 the cycle after tx_finish; busy high throughout.
- All requesting: req=1111 held -> grant order 0,1,2,3,0, each with its own payload; exactly one ack per frame.
- Mid-transfer changes: requester 2 drops req and changes req_data to 0x00 during WAIT_FIN -> tx_data stays at its original 0x3C and ack[2] still pulses.
- Reset mid-transfer: reset_n low during WAIT_FIN -> all outputs 0 immediately; no ack after release; the next request is served from rr_ptr=0.
- Stray finish: tx_finish pulsed while IDLE -> no state change, no ack.
- Timeout (EDABK_TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=20): model never asserts tx_finish -> after 20 cycles timeout_err=1 and stays set, ack pulses, and the next request proceeds normally.
